// File: rtl/poly_pkg.sv
// poly_pkg: shared types and limits for the Horner polynomial evaluator.
// Holds the FSM state enum, the maximum degree and the step-counter width.
package poly_pkg;

  localparam int MAX_DEGREE = 15;
  localparam int KW = $clog2(MAX_DEGREE + 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    ADD,
    DONE
  } state_e;

endpackage

// File: rtl/poly_ctrl.sv
// poly_ctrl: sequencer for horner_poly_eval (FSM, step counter k, BUSY/FINISHED).
// Ports: clk_i, rst_ni, start_i in; accept/mul/add/last strobes, k_o, busy_o, fin_o out.
module poly_ctrl
  import poly_pkg::*;
#(
  parameter int DEGREE = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  output logic          accept_o,
  output logic          mul_o,
  output logic          add_o,
  output logic          last_o,
  output logic [KW-1:0] k_o,
  output logic          busy_o,
  output logic          fin_o
);

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic          busy_q, busy_d;
  logic          fin_q, fin_d;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    accept_o = 1'b0;
    mul_o    = 1'b0;
    add_o    = 1'b0;
    last_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          accept_o = 1'b1;
          k_d      = KW'(DEGREE - 1);
          state_d  = MUL;
        end
      end
      MUL: begin
        mul_o   = 1'b1;
        state_d = ADD;
      end
      ADD: begin
        add_o = 1'b1;
        if (k_q == '0) begin
          last_o  = 1'b1;
          state_d = DONE;
        end else begin
          k_d     = k_q - KW'(1);
          state_d = MUL;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Flags follow the next state so they leave as registers.
    busy_d = (state_d != IDLE);
    fin_d  = (state_d == DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      k_q     <= '0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
    end
  end

  assign k_o    = k_q;
  assign busy_o = busy_q;
  assign fin_o  = fin_q;

endmodule

// File: rtl/horner_poly_eval.sv
// horner_poly_eval: signed polynomial evaluator, one multiply or add per clock.
// Ports: clk, RST_n, START, X, COEF in; BUSY, FINISHED, Resultado, Overflow out.
module horner_poly_eval
  import poly_pkg::*;
#(
  parameter int DEGREE = 2,
  parameter int XW     = 8,
  parameter int DW     = 16
) (
  input  logic                       clk,
  input  logic                       RST_n,
  input  logic                       START,
  input  logic signed [XW-1:0]       X,
  input  logic [(DEGREE+1)*DW-1:0]   COEF,
  output logic                       BUSY,
  output logic                       FINISHED,
  output logic signed [DW-1:0]       Resultado,
  output logic                       Overflow
);

  if (DEGREE < 1 || DEGREE > MAX_DEGREE) begin : g_bad_degree
    $error("horner_poly_eval: DEGREE out of range");
  end

  localparam int PW = DW + XW;
  localparam int CW = (DEGREE + 1) * DW;

  logic          accept, do_mul, do_add, last;
  logic [KW-1:0] k;

  poly_ctrl #(
    .DEGREE(DEGREE)
  ) u_ctrl (
    .clk_i   (clk),
    .rst_ni  (RST_n),
    .start_i (START),
    .accept_o(accept),
    .mul_o   (do_mul),
    .add_o   (do_add),
    .last_o  (last),
    .k_o     (k),
    .busy_o  (BUSY),
    .fin_o   (FINISHED)
  );

  logic signed [XW-1:0] x_q, x_d;
  logic [CW-1:0]        coef_q, coef_d;
  logic signed [DW-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic signed [DW-1:0] res_q, res_d;
  logic                 ovo_q, ovo_d;

  // Pad the coefficient table to a power of two so k indexes it exactly.
  logic [DW-1:0] coef_a [MAX_DEGREE+1];
  for (genvar g = 0; g <= MAX_DEGREE; g++) begin : g_coef
    if (g <= DEGREE) begin : g_on
      assign coef_a[g] = coef_q[g*DW +: DW];
    end else begin : g_off
      assign coef_a[g] = '0;
    end
  end

  logic signed [DW-1:0] ak;
  logic signed [PW-1:0] p;
  logic signed [DW:0]   s;
  logic                 mul_ovf, add_ovf;

  assign ak = coef_a[k];
  assign p  = PW'(acc_q) * PW'(x_q);
  assign s  = (DW+1)'(acc_q) + (DW+1)'(ak);
  // Product fits only if its top XW+1 bits are all copies of the sign.
  assign mul_ovf = (p != {{XW{p[DW-1]}}, p[DW-1:0]});
  assign add_ovf = s[DW] ^ s[DW-1];

  always_comb begin
    x_d    = x_q;
    coef_d = coef_q;
    acc_d  = acc_q;
    ovf_d  = ovf_q;
    res_d  = res_q;
    ovo_d  = ovo_q;
    unique case (1'b1)
      accept: begin
        x_d    = X;
        coef_d = COEF;
        acc_d  = COEF[DEGREE*DW +: DW];
        ovf_d  = 1'b0;
      end
      do_mul: begin
        acc_d = p[DW-1:0];
        ovf_d = ovf_q | mul_ovf;
      end
      do_add: begin
        acc_d = s[DW-1:0];
        ovf_d = ovf_q | add_ovf;
        if (last) begin
          res_d = s[DW-1:0];
          ovo_d = ovf_q | add_ovf;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      x_q    <= '0;
      coef_q <= '0;
      acc_q  <= '0;
      ovf_q  <= 1'b0;
      res_q  <= '0;
      ovo_q  <= 1'b0;
    end else begin
      x_q    <= x_d;
      coef_q <= coef_d;
      acc_q  <= acc_d;
      ovf_q  <= ovf_d;
      res_q  <= res_d;
      ovo_q  <= ovo_d;
    end
  end

  assign Resultado = res_q;
  assign Overflow  = ovo_q;

endmodule

// File: tb/tb_horner_poly_eval.sv
// tb_horner_poly_eval: directed checks of horner_poly_eval at DEGREE 1, 2, 3.
// Hand-computed results, FINISHED timing, START ignore, reset abort.
module tb_horner_poly_eval;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start1, start2, start3;
  logic signed [7:0] x1, x2, x3;
  logic [31:0] coef1;
  logic [47:0] coef2;
  logic [63:0] coef3;
  logic busy1, busy2, busy3;
  logic fin1, fin2, fin3;
  logic ovf1, ovf2, ovf3;
  logic signed [15:0] res1, res2, res3;

  int n_tests = 0;
  int n_fail  = 0;

  horner_poly_eval #(.DEGREE(1), .XW(8), .DW(16)) u_deg1 (
    .clk(clk), .RST_n(rst_n), .START(start1), .X(x1), .COEF(coef1),
    .BUSY(busy1), .FINISHED(fin1), .Resultado(res1), .Overflow(ovf1)
  );

  horner_poly_eval #(.DEGREE(2), .XW(8), .DW(16)) u_deg2 (
    .clk(clk), .RST_n(rst_n), .START(start2), .X(x2), .COEF(coef2),
    .BUSY(busy2), .FINISHED(fin2), .Resultado(res2), .Overflow(ovf2)
  );

  horner_poly_eval #(.DEGREE(3), .XW(8), .DW(16)) u_deg3 (
    .clk(clk), .RST_n(rst_n), .START(start3), .X(x3), .COEF(coef3),
    .BUSY(busy3), .FINISHED(fin3), .Resultado(res3), .Overflow(ovf3)
  );

  task automatic check(input string tag,
                       input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic fin_of(input int which);
    case (which)
      1: return fin1;
      3: return fin3;
      default: return fin2;
    endcase
  endfunction

  function automatic logic busy_of(input int which);
    case (which)
      1: return busy1;
      3: return busy3;
      default: return busy2;
    endcase
  endfunction

  // Caller raises START; edge 0 is the next rising edge.
  // Returns the edge index of the FINISHED pulse, -1 if none in budget.
  task automatic go(input int which, input bit poke, output int n);
    n = -1;
    @(posedge clk); #1;
    start1 = 1'b0;
    start2 = 1'b0;
    start3 = 1'b0;
    check("busy_after_accept", busy_of(which), 1);
    for (int i = 1; i <= 40 && n < 0; i++) begin
      @(posedge clk); #1;
      if (poke && i == 1) begin
        x2     = 8'sd5;
        coef2  = {16'sd9, 16'sd9, 16'sd9};
        start2 = 1'b1;
      end
      if (poke && i == 2) start2 = 1'b0;
      if (fin_of(which)) n = i;
    end
  endtask

  int n, np, p0, p1;
  bit saw_fin;

  initial begin
    rst_n  = 1'b0;
    start1 = 1'b0; start2 = 1'b0; start3 = 1'b0;
    x1 = '0; x2 = '0; x3 = '0;
    coef1 = '0; coef2 = '0; coef3 = '0;
    #12;
    check("rst_res", res2, 0);
    check("rst_ovf", ovf2, 0);
    check("rst_busy", busy2, 0);
    check("rst_fin", fin2, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 3x^2+4x+5 at x=-20
    x2 = -8'sd20; coef2 = {16'sd3, 16'sd4, 16'sd5}; start2 = 1'b1;
    go(2, 1'b0, n);
    check("t1_fin_edge", n, 4);
    check("t1_res", res2, 1125);
    check("t1_ovf", ovf2, 0);
    @(posedge clk); #1;
    check("t1_fin_drop", fin2, 0);
    check("t1_idle", busy2, 0);

    // add overflow on the last step
    x2 = 8'sd6; coef2 = {16'sd4, 16'sd5, 16'sd32767}; start2 = 1'b1;
    go(2, 1'b0, n);
    check("t2_fin_edge", n, 4);
    check("t2_res", res2, -32595);
    check("t2_ovf", ovf2, 1);
    @(posedge clk); #1;

    // clean run clears the flag
    x2 = 8'sd1; coef2 = {16'sd0, 16'sd0, 16'sd7}; start2 = 1'b1;
    go(2, 1'b0, n);
    check("t3_res", res2, 7);
    check("t3_ovf", ovf2, 0);
    @(posedge clk); #1;

    // re-START with new operands while busy is ignored
    x2 = 8'sd3; coef2 = {16'sd1, 16'sd1, 16'sd1}; start2 = 1'b1;
    go(2, 1'b1, n);
    check("t4_fin_edge", n, 4);
    check("t4_res", res2, 13);
    check("t4_ovf", ovf2, 0);
    @(posedge clk); #1;
    check("t4_no_requeue", busy2, 0);

    // START held high: one result every 6 cycles
    x2 = 8'sd1; coef2 = {16'sd0, 16'sd0, 16'sd7}; start2 = 1'b1;
    np = 0; p0 = -1; p1 = -1;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (fin2) begin
        if (np == 0) p0 = i;
        else if (np == 1) p1 = i;
        np++;
      end
    end
    start2 = 1'b0;
    check("held_first", p0, 4);
    check("held_gap", p1 - p0, 6);
    check("held_count", np, 2);
    repeat (6) @(posedge clk);
    #1;
    check("held_idle", busy2, 0);

    // reset at edge 2 aborts the operation
    x2 = -8'sd20; coef2 = {16'sd3, 16'sd4, 16'sd5}; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_res", res2, 0);
    check("abort_busy", busy2, 0);
    check("abort_fin", fin2, 0);
    check("abort_ovf", ovf2, 0);
    saw_fin = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (fin2) saw_fin = 1'b1;
    end
    check("abort_no_fin", saw_fin, 0);
    rst_n = 1'b1; start2 = 1'b1;
    go(2, 1'b0, n);
    check("post_rst_edge", n, 4);
    check("post_rst_res", res2, 1125);
    @(posedge clk); #1;

    // degree 3, multiply overflow, truncates to 0
    x3 = -8'sd128;
    coef3 = {16'sd1, 16'sd0, 16'sd0, 16'sd0};
    start3 = 1'b1;
    go(3, 1'b0, n);
    check("d3_fin_edge", n, 6);
    check("d3_res", res3, 0);
    check("d3_ovf", ovf3, 1);
    @(posedge clk); #1;

    // degree 1, -32768 * -1 wraps
    x1 = -8'sd1; coef1 = {16'h8000, 16'h0000}; start1 = 1'b1;
    go(1, 1'b0, n);
    check("d1_fin_edge", n, 2);
    check("d1_res", res1, -32768);
    check("d1_ovf", ovf1, 1);
    @(posedge clk); #1;
    check("d1_idle", busy1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/horner_poly_eval.md
# horner_poly_eval

Parametrised signed polynomial evaluator: computes Resultado = sum(a_k * X^k, k=0..DEGREE) by Horner's rule, one multiply or one add per clock. It generalises the fixed second-order controller/datapath pair to any degree and operand widths, adds a BUSY/FINISHED handshake and a per-operation overflow flag, and merges both halves into one block. It sits between the operand registers and the result/display logic.

## Interface
- DEGREE, 2: polynomial order; legal range 1..15.
- XW, 8: width of X, signed two's complement.
- DW, 16: width of each coefficient, the accumulator and Resultado, all signed two's complement.
- clk  in  1  single clock, rising edge.
- RST_n  in  1  reset, asynchronous, active-low.
- START  in  1  request; sampled only in IDLE.
- X  in  XW  evaluation point; captured on START acceptance.
- COEF  in  (DEGREE+1)*DW  packed coefficients; COEF[k*DW +: DW] = a_k; captured on START acceptance.
- BUSY  out  1  high from the acceptance edge until the edge that leaves DONE.
- FINISHED  out  1  one-cycle pulse; Resultado and Overflow are valid.
- Resultado  out  DW  last completed result; held until the next completion.
- Overflow  out  1  high if any step of the last completed operation overflowed.

## Operation
- States: IDLE, MUL, ADD, DONE.
- IDLE, START=1 at an edge: latch X and COEF, acc <= a_DEGREE, k <= DEGREE-1, clear the internal overflow flag, go to MUL. START=0: stay in IDLE.
- MUL: compute p = acc * X at full width DW+XW. Set acc <= p[DW-1:0]. Flag overflow if p is not the sign extension of p[DW-1:0]. Go to ADD.
- ADD: compute s = acc + a_k at DW+1 bits. Set acc <= s[DW-1:0]. Flag overflow if s[DW] != s[DW-1].
  - k==0: go to DONE and load Resultado <= s[DW-1:0] and Overflow <= the internal flag OR the current step's overflow.
  - otherwise: k <= k-1, go to MUL.
- Overflow does not stop the evaluation: it continues with wrapped values. The flag is sticky for the rest of the operation.
- DONE: FINISHED=1 for this one cycle. Always go to IDLE on the next edge.
- START outside IDLE is ignored, including in DONE. No queueing.
- Changes to X or COEF after acceptance have no effect on the operation in flight.

## Timing
- Reset, asynchronous: state IDLE; BUSY, FINISHED, Overflow = 0; Resultado = 0; acc and k = 0.
- Let edge 0 be the acceptance edge. The FSM enters DONE at edge 2*DEGREE, so FINISHED is high between edges 2*DEGREE and 2*DEGREE+1.
- Resultado and Overflow change only at the edge that enters DONE.
- Earliest next acceptance is edge 2*DEGREE+2. With START held high, the throughput is one result per 2*DEGREE+2 cycles.
- RST_n low mid-operation aborts the operation:
  - no FINISHED pulse;
  - Resultado returns to 0;
  - START is honoured on the first edge after release.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package poly_pkg holds:
  - the state enum (IDLE, MUL, ADD, DONE);
  - localparams MAX_DEGREE = 15 and the step-counter width = $clog2(MAX_DEGREE+1).
- Split into two parts, mirroring the existing controller/datapath partition:
  - sub-module poly_ctrl: FSM, k counter, BUSY/FINISHED, mux and load enables;
  - top level: datapath (coefficient and X registers, accumulator, multiplier, adder, overflow logic).
- Compile-time assertion: DEGREE must be in 1..MAX_DEGREE.

## Test plan
- DEGREE=2, X=-20, COEF={a2=3, a1=4, a0=5}, START pulse -> FINISHED is high exactly between edges 4 and 5; Resultado=1125, Overflow=0.
- DEGREE=2, X=6, {4, 5, 32767} -> Resultado = 32941 wrapped to 16 bits = -32595; Overflow=1. A following clean operation with X=1, {0, 0, 7} -> Resultado=7, Overflow=0.
- DEGREE=3, XW=8, DW=16, X=-128, {a3=1, a2=0, a1=0, a0=0} -> the multiply step overflows; Overflow=1, Resultado = -2097152 truncated to 16 bits = 0.
- START re-pulsed with new X/COEF while BUSY -> ignored; Resultado matches the first operands. START held high -> FINISHED pulses every 2*DEGREE+2 cycles.
- RST_n driven low at edge 2 of a DEGREE=2 operation -> all outputs 0 immediately, no FINISHED. After release, a new START completes normally.
- DEGREE=1, X=-1, {a1=-32768, a0=0} -> Resultado = -32768 (32768 wrapped); Overflow=1; FINISHED at edge 2.
